// File: rtl/sinc_decim_if.sv
// ============================================================================
// Module  : sinc_decim_if
// Brief   : Sample-in / decimated-result-out bundle for sinc_decim.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface sinc_decim_if #(
    parameter int ADC_WIDTH = 8,
    parameter int DSEL_W    = 3
) ();
    logic                 sample;
    logic [ADC_WIDTH-1:0] raw_data_in;
    logic [DSEL_W-1:0]    dec_bits;
    logic [ADC_WIDTH-1:0] ave_data_out;
    logic                 data_out_valid;
    logic                 data_out_ready;
    logic                 overrun;

    modport slave (
        input  sample, raw_data_in, dec_bits, data_out_ready,
        output ave_data_out, data_out_valid, overrun
    );

    modport master (
        output sample, raw_data_in, dec_bits, data_out_ready,
        input  ave_data_out, data_out_valid, overrun
    );
endinterface

`default_nettype wire

// File: rtl/sinc_decim.sv
// ============================================================================
// Module  : sinc_decim
// Brief   : sinc^ORDER (CIC) decimator, power-of-two runtime rate, valid/ready
//           output with sticky overrun. Define ROUND_EN for round-half-up.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module sinc_decim #(
    parameter int ADC_WIDTH    = 8,
    parameter int ORDER        = 3,
    parameter int MAX_DEC_BITS = 6,
    parameter int DSEL_W       = 3
) (
    input  wire logic    clk,
    input  wire logic    rst,
    sinc_decim_if.slave  bus
);
    localparam int                c_ACC_W   = ADC_WIDTH + ORDER * MAX_DEC_BITS;
    localparam int                c_SH_W    = $clog2(ORDER * MAX_DEC_BITS + 1);
    localparam logic [1:0]        c_SETTLE  = 2'(ORDER);
    localparam logic [DSEL_W-1:0] c_DEC_MAX = DSEL_W'(MAX_DEC_BITS);

    logic                    r_sample_d1, r_sample_d2;
    logic [ADC_WIDTH-1:0]    r_raw_d1;
    logic [DSEL_W-1:0]       r_dec_eff;
    logic [DSEL_W-1:0]       w_dec_clamp;
    logic                    w_acc, w_flush, w_tick;

    logic [MAX_DEC_BITS-1:0] r_phase;
    logic [MAX_DEC_BITS:0]   w_r, w_rm1;
    logic [MAX_DEC_BITS-1:0] w_rmax;

    logic [c_ACC_W-1:0]      r_int     [ORDER];
    logic [c_ACC_W-1:0]      w_int_nxt [ORDER];
    logic [c_ACC_W-1:0]      r_cap;
    logic [c_ACC_W-1:0]      r_comb    [ORDER];
    logic [c_ACC_W-1:0]      r_prev    [ORDER];
    logic [c_ACC_W-1:0]      w_comb_in [ORDER];
    logic [ORDER:0]          r_vld;
    logic [1:0]              r_settle;

    logic [c_SH_W-1:0]       w_shift;
    logic [ADC_WIDTH-1:0]    w_result;
    logic                    w_load, w_xfer;
    logic [ADC_WIDTH-1:0]    r_data;
    logic                    r_valid, r_ovr;

    assign w_dec_clamp = (bus.dec_bits > c_DEC_MAX) ? c_DEC_MAX : bus.dec_bits;
    assign w_acc       = r_sample_d1 & ~r_sample_d2;
    assign w_flush     = (w_dec_clamp != r_dec_eff);

    // R-1 computed one bit wider so R = 2^MAX_DEC_BITS yields all ones
    assign w_r    = (MAX_DEC_BITS+1)'(1) << r_dec_eff;
    assign w_rm1  = w_r - (MAX_DEC_BITS+1)'(1);
    assign w_rmax = w_rm1[MAX_DEC_BITS-1:0];
    assign w_tick = w_acc && (r_phase == w_rmax);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sample_d1 <= 1'b0;
            r_sample_d2 <= 1'b0;
            r_raw_d1    <= '0;
            r_dec_eff   <= '0;
        end else begin
            r_sample_d1 <= bus.sample;
            r_sample_d2 <= r_sample_d1;
            r_raw_d1    <= bus.raw_data_in;
            r_dec_eff   <= w_dec_clamp;
        end
    end

    always_comb begin
        w_int_nxt[0] = r_int[0] + {{(c_ACC_W-ADC_WIDTH){1'b0}}, r_raw_d1};
        for (int k = 1; k < ORDER; k++) begin
            w_int_nxt[k] = r_int[k] + r_int[k-1];
        end
        w_comb_in[0] = r_cap;
        for (int k = 1; k < ORDER; k++) begin
            w_comb_in[k] = r_comb[k-1];
        end
    end

    // Integrators wrap modulo 2^c_ACC_W; the comb differences cancel it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < ORDER; k++) begin
                r_int[k]  <= '0;
                r_comb[k] <= '0;
                r_prev[k] <= '0;
            end
            r_cap    <= '0;
            r_phase  <= '0;
            r_vld    <= '0;
            r_settle <= '0;
        end else if (w_flush) begin
            for (int k = 0; k < ORDER; k++) begin
                r_int[k]  <= '0;
                r_comb[k] <= '0;
                r_prev[k] <= '0;
            end
            r_cap    <= '0;
            r_phase  <= '0;
            r_vld    <= '0;
            r_settle <= '0;
        end else begin
            if (w_acc) begin
                for (int k = 0; k < ORDER; k++) begin
                    r_int[k] <= w_int_nxt[k];
                end
                r_phase <= (r_phase == w_rmax) ? '0 : r_phase + 1'b1;
            end
            r_vld[0] <= w_tick;
            if (w_tick) begin
                r_cap <= w_int_nxt[ORDER-1];
            end
            for (int k = 0; k < ORDER; k++) begin
                if (r_vld[k]) begin
                    r_comb[k] <= w_comb_in[k] - r_prev[k];
                    r_prev[k] <= w_comb_in[k];
                end
                r_vld[k+1] <= r_vld[k];
            end
            if (r_vld[ORDER] && (r_settle != c_SETTLE)) begin
                r_settle <= r_settle + 2'd1;
            end
        end
    end

    assign w_shift = c_SH_W'(ORDER * int'(r_dec_eff));

`ifdef ROUND_EN
    localparam int c_OUT_MAX = (1 << ADC_WIDTH) - 1;
    logic [c_ACC_W:0] w_half, w_rsum, w_rshr;

    always_comb begin
        w_half = '0;
        if (w_shift != '0) begin
            w_half = (c_ACC_W+1)'(1) << (w_shift - c_SH_W'(1));
        end
        w_rsum = {1'b0, r_comb[ORDER-1]} + w_half;
        w_rshr = w_rsum >> w_shift;
        if (w_rshr > (c_ACC_W+1)'(c_OUT_MAX)) begin
            w_result = '1;
        end else begin
            w_result = w_rshr[ADC_WIDTH-1:0];
        end
    end
`else
    assign w_result = ADC_WIDTH'(r_comb[ORDER-1] >> w_shift);
`endif

    assign w_load = r_vld[ORDER] && (r_settle == c_SETTLE);
    assign w_xfer = r_valid && bus.data_out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end else if (w_load) begin
            r_data  <= w_result;
            r_valid <= 1'b1;
            if (r_valid && !bus.data_out_ready) begin
                r_ovr <= 1'b1;
            end else if (w_xfer) begin
                r_ovr <= 1'b0;
            end
        end else if (w_xfer) begin
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end
    end

    assign bus.ave_data_out   = r_data;
    assign bus.data_out_valid = r_valid;
    assign bus.overrun        = r_ovr;

endmodule

`default_nettype wire

// File: tb/tb_sinc_decim.sv
// ============================================================================
// Module  : tb_sinc_decim
// Brief   : Directed table-driven bench for sinc_decim, ORDER=1 and ORDER=3.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sinc_decim;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sinc_decim_if #(.ADC_WIDTH(8), .DSEL_W(3)) bus1 ();
    sinc_decim_if #(.ADC_WIDTH(8), .DSEL_W(3)) bus3 ();

    sinc_decim #(.ADC_WIDTH(8), .ORDER(1), .MAX_DEC_BITS(6), .DSEL_W(3)) u_o1 (
        .clk(clk), .rst(rst), .bus(bus1.slave));
    sinc_decim #(.ADC_WIDTH(8), .ORDER(3), .MAX_DEC_BITS(6), .DSEL_W(3)) u_o3 (
        .clk(clk), .rst(rst), .bus(bus3.slave));

    logic [1:0] v, r, ov;
    logic [7:0] d [2];
    assign v    = {bus3.data_out_valid, bus1.data_out_valid};
    assign r    = {bus3.data_out_ready, bus1.data_out_ready};
    assign ov   = {bus3.overrun, bus1.overrun};
    assign d[0] = bus1.ave_data_out;
    assign d[1] = bus3.ave_data_out;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Transfer monitor: counts accepted results, checks value and spacing
    int mon_cnt [2];
    int mon_last [2];
    int mon_bad [2];
    int mon_gapbad [2];
    int mon_lastcyc [2];
    int mon_exp;
    int mon_gap;

    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (v[s] && r[s]) begin
                if (mon_cnt[s] > 0 && mon_gap > 0 && (cyc - mon_lastcyc[s]) != mon_gap)
                    mon_gapbad[s] <= mon_gapbad[s] + 1;
                if (int'(d[s]) != mon_exp) mon_bad[s] <= mon_bad[s] + 1;
                mon_cnt[s]     <= mon_cnt[s] + 1;
                mon_last[s]    <= int'(d[s]);
                mon_lastcyc[s] <= cyc;
            end
        end
    end

    task automatic mon_clear(input int exp, input int gap);
        for (int s = 0; s < 2; s++) begin
            mon_cnt[s] = 0; mon_last[s] = -1; mon_bad[s] = 0; mon_gapbad[s] = 0; mon_lastcyc[s] = 0;
        end
        mon_exp = exp;
        mon_gap = gap;
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_dec(input int dec);
        bus1.dec_bits = 3'(dec);
        bus3.dec_bits = 3'(dec);
    endtask

    task automatic send(input int val);
        bus1.raw_data_in = 8'(val);
        bus3.raw_data_in = 8'(val);
        bus1.sample = 1'b1;
        bus3.sample = 1'b1;
        tick_n(1);
        bus1.sample = 1'b0;
        bus3.sample = 1'b0;
        tick_n(3);
    endtask

    task automatic do_reset();
        bus1.sample = 1'b0;
        bus3.sample = 1'b0;
        rst = 1'b1;
        tick_n(2);
        rst = 1'b0;
        tick_n(1);
    endtask

    typedef struct {
        int sel;       // 0: ORDER=1 instance, 1: ORDER=3 instance
        int dec;
        int val;
        bit alt;       // samples alternate 0,val
        int nsamp;
        int exp_data;
        int exp_cnt;
        int gap;       // clocks between accepted results
    } vec_t;

    vec_t tbl [7];
    int   ov_seq [8];
    int   rnd_exp;

    initial begin
        rst = 1'b1;
        bus1.sample = 1'b0; bus3.sample = 1'b0;
        bus1.raw_data_in = '0; bus3.raw_data_in = '0;
        bus1.dec_bits = '0; bus3.dec_bits = '0;
        bus1.data_out_ready = 1'b1; bus3.data_out_ready = 1'b1;
        mon_clear(0, 0);

`ifdef ROUND_EN
        rnd_exp = 1;
`else
        rnd_exp = 0;
`endif
        tbl[0] = '{sel: 0, dec: 2, val: 100, alt: 0, nsamp: 20,  exp_data: 100,     exp_cnt: 4, gap: 16};
        tbl[1] = '{sel: 1, dec: 2, val: 200, alt: 0, nsamp: 28,  exp_data: 200,     exp_cnt: 4, gap: 16};
        tbl[2] = '{sel: 1, dec: 6, val: 255, alt: 0, nsamp: 400, exp_data: 255,     exp_cnt: 3, gap: 256};
        tbl[3] = '{sel: 0, dec: 7, val: 33,  alt: 0, nsamp: 192, exp_data: 33,      exp_cnt: 2, gap: 256};
        tbl[4] = '{sel: 0, dec: 0, val: 17,  alt: 0, nsamp: 6,   exp_data: 17,      exp_cnt: 5, gap: 4};
        tbl[5] = '{sel: 0, dec: 1, val: 1,   alt: 1, nsamp: 10,  exp_data: rnd_exp, exp_cnt: 4, gap: 8};
        tbl[6] = '{sel: 1, dec: 0, val: 50,  alt: 0, nsamp: 8,   exp_data: 50,      exp_cnt: 5, gap: 4};

        for (int i = 0; i < 7; i++) begin
            do_reset();
            check($sformatf("v%0d reset valid", i), int'(v[tbl[i].sel]), 0);
            check($sformatf("v%0d reset data", i), int'(d[tbl[i].sel]), 0);
            set_dec(tbl[i].dec);
            tick_n(3);
            mon_clear(tbl[i].exp_data, tbl[i].gap);
            for (int j = 0; j < tbl[i].nsamp; j++)
                send((tbl[i].alt && (j % 2 == 0)) ? 0 : tbl[i].val);
            tick_n(12);
            check($sformatf("v%0d result count", i), mon_cnt[tbl[i].sel], tbl[i].exp_cnt);
            check($sformatf("v%0d last data", i), mon_last[tbl[i].sel], tbl[i].exp_data);
            check($sformatf("v%0d bad data count", i), mon_bad[tbl[i].sel], 0);
            check($sformatf("v%0d spacing errors", i), mon_gapbad[tbl[i].sel], 0);
            check($sformatf("v%0d overrun", i), int'(ov[tbl[i].sel]), 0);
        end

        // Overrun: three results pile up while the consumer stalls
        ov_seq = '{5, 5, 10, 10, 20, 20, 40, 40};
        do_reset();
        set_dec(1);
        tick_n(3);
        bus1.data_out_ready = 1'b0;
        for (int j = 0; j < 8; j++) send(ov_seq[j]);
        tick_n(10);
        check("ovr held valid", int'(bus1.data_out_valid), 1);
        check("ovr third result", int'(bus1.ave_data_out), 40);
        check("ovr sticky flag", int'(bus1.overrun), 1);
        bus1.data_out_ready = 1'b1;
        tick_n(1);
        check("ovr valid after accept", int'(bus1.data_out_valid), 0);
        check("ovr flag after accept", int'(bus1.overrun), 0);

        // Rate change mid-period flushes the ORDER=3 pipeline
        do_reset();
        set_dec(2);
        tick_n(3);
        mon_clear(77, 0);
        for (int j = 0; j < 18; j++) send(77);
        tick_n(10);
        check("flush pre-change count", mon_cnt[1], 1);
        set_dec(3);
        tick_n(2);
        mon_clear(77, 0);
        for (int j = 0; j < 31; j++) send(77);
        tick_n(10);
        check("flush settling withheld", mon_cnt[1], 0);
        send(77);
        tick_n(10);
        check("flush first result count", mon_cnt[1], 1);
        check("flush first result data", mon_last[1], 77);
        check("flush overrun", int'(bus3.overrun), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/sinc_decim.md
Name: sinc_decim

Overview:
Parametrised sinc^ORDER (CIC) decimating low-pass filter; generalises the box averager, which is the ORDER=1 case, to higher order and a runtime-selectable power-of-two decimation rate.
Sits between the sigma-delta modulator's raw sample stream and downstream consumers.
Adds a valid/ready output handshake with overrun detection, CIC settling suppression, and automatic flush on rate change.

Parameters:
ADC_WIDTH, 8, unsigned input/output sample width
ORDER, 3, filter order (integrator/comb stage count), legal 1..3
MAX_DEC_BITS, 6, largest log2 decimation rate supported
DSEL_W, 3, width of dec_bits; must be >= clog2(MAX_DEC_BITS+1)

Ports:
clk  in  1  sample rate clock
rst  in  1  asynchronous reset, active-high
sample  in  1  raw_data_in valid on rising edge of this strobe
raw_data_in  in  ADC_WIDTH  unsigned raw sample
dec_bits  in  DSEL_W  log2 decimation rate R; values > MAX_DEC_BITS clamp to MAX_DEC_BITS
ave_data_out  out  ADC_WIDTH  filtered, decimated result
data_out_valid  out  1  result held valid until accepted
data_out_ready  in  1  consumer accepts when valid && ready
overrun  out  1  sticky: unaccepted result was overwritten

Behaviour:
- Reset (rst high, async): all outputs 0; integrators, combs, phase counter and settle counter 0; edge/data pipeline registers 0.
- Front end: sample and raw_data_in each pass through 1 register. accumulate = sample_d1 && !sample_d2. Exactly one accumulate per rising sample edge.
- Integrators: ORDER cascaded registers, width ACC_W = ADC_WIDTH + ORDER*MAX_DEC_BITS. Each updates only on accumulate.
  - int1 += raw_data_d1.
  - int(k) += registered int(k-1).
  - Modular wrap-around, no saturation; comb differencing cancels the wrap.
- Phase counter: MAX_DEC_BITS wide. Increments on accumulate. Wraps to 0 when count == R-1, R = 2^dec_eff.
  - tick = accumulate && count == R-1.
  - dec_eff = 0 gives R=1: every accumulate is a tick.
- Combs: ORDER pipelined stages, delay 1 (at decimated rate), each registered and enabled by its own valid bit shifted from tick.
  - Stage k: out = in - prev_in; prev_in <= in.
  - Input to comb1 is the last integrator's value captured on tick.
- Scaling: comb result >> (ORDER*dec_eff). Result always fits ADC_WIDTH; no saturation needed.
- Latency: tick in cycle A -> ave_data_out/valid update at the edge ending cycle A+ORDER+1. Fully pipelined: back-to-back ticks every 2 clocks are legal.
- Settling: the first ORDER comb outputs after reset or flush are discarded (no valid, no data change). A settle counter saturates at ORDER.
- Flush: dec_eff is registered.
  - Any change of the registered value in a cycle zeroes integrators, combs, phase and settle counters on the next edge.
  - Output register, valid and overrun are untouched.
  - A sample arriving in the flush cycle is dropped.
- Handshake:
  - Transfer = valid && ready. Valid is cleared on transfer unless a new result loads in the same cycle.
  - New result while valid && !ready: data overwritten, valid stays 1, overrun <= 1.
  - New result and transfer in the same cycle: new data loaded, valid stays 1, no overrun.
  - overrun is cleared on any transfer without a simultaneous overwrite.

Optional Feature:
ROUND_EN defined: add 2^(ORDER*dec_eff-1) before the shift (round half up). Skip when dec_eff = 0. Clamp to 2^ADC_WIDTH-1.
Undefined: plain truncation; no rounding adder or clamp is generated.

Test Plan:
- ORDER=1, dec_bits=2, ready=1, constant 100 every 4 clk -> valid pulse every 16 clk, ave_data_out=100, first output suppressed.
- ORDER=3, dec_bits=2, constant 200 -> first 3 decimated results withheld, 4th onward =200, overrun=0.
- ORDER=3, dec_bits=6, constant 255 for 400 samples -> integrators wrap, every settled output =255.
- ORDER=1, dec_bits=1, ready=0, 3 results -> valid held, data = third result, overrun=1. ready=1 for one cycle -> valid=0, overrun=0.
- dec_bits 2->3 mid-period -> flush, next valid only after ORDER+1 full 8-sample periods, correct average of constant input.
- ROUND_EN, ORDER=1, dec_bits=1, samples alternating 0,1 -> output 1. Without macro -> output 0.
